// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle sequencer for the RV32I subset (addi, bne, lw). Steps the
//   shared datapath through FETCH/DECODE/EXEC/MEM/WB with ready handshakes
//   to the instruction and data memories, flags illegal instructions and
//   memory timeouts, and counts retired instructions.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   op, funct3               IR fields, valid from DECODE onward
//   EQ                       ALU equal flag, valid in EXEC
//   imem_ready, dmem_ready   memory data-valid handshakes
//   imem_req, dmem_req       fetch / load requests
//   IRWrite, PCWrite, PCsrc  IR load, PC update, PC source (1 = branch target)
//   RegWrite                 register file write enable
//   ALUctrl, ALUsrc, ImmSrc  ALU operation, operand B select, immediate format
//   Resultsrc                write-back source (1 = memory data)
//   illegal, timeout         sticky error flags
//   retired                  retired-instruction count (wraps)
//   state_o                  current state encoding
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | request instruction, load IR when imem_ready
// DECODE | classify {op, funct3}, latch class or halt as illegal
// EXEC   | ALU step; bne retires here with the branch decision
// MEM    | lw only, wait for dmem_ready
// WB     | register write, PC+4, retire
// HALT   | dead until reset (illegal or timeout)

module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             EQ,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCsrc,
  output logic             RegWrite,
  output logic [2:0]       ALUctrl,
  output logic             ALUsrc,
  output logic [1:0]       ImmSrc,
  output logic             Resultsrc,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_ADDI = 2'd1,
    C_LW   = 2'd2,
    C_BNE  = 2'd3
  } cls_t;

  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit                TO_EN     = (TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state, state_next;
  cls_t              cls, cls_next, dec_cls;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              retire, set_illegal, set_timeout;

  logic       imem_req_d, dmem_req_d, irwrite_d, pcwrite_d, pcsrc_d;
  logic       regwrite_d, alusrc_d, resultsrc_d;
  logic [2:0] aluctrl_d;
  logic [1:0] immsrc_d;

  always_comb begin
    unique case ({op, funct3})
      {7'b0010011, 3'b000}: dec_cls = C_ADDI;
      {7'b0000011, 3'b010}: dec_cls = C_LW;
      {7'b1100011, 3'b001}: dec_cls = C_BNE;
      default:              dec_cls = C_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      cls      <= C_NONE;
      wait_cnt <= '0;
      retired  <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      cls      <= cls_next;
      // Anything other than a stall in FETCH/MEM clears the counter, so it
      // always starts from zero on entry to either waiting state.
      wait_cnt <= wait_inc ? wait_cnt + WAIT_W'(1) : '0;
      if (retire)      retired <= retired + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    cls_next    = cls;
    wait_inc    = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    imem_req_d  = 1'b0;
    dmem_req_d  = 1'b0;
    irwrite_d   = 1'b0;
    pcwrite_d   = 1'b0;
    pcsrc_d     = 1'b0;
    regwrite_d  = 1'b0;
    aluctrl_d   = 3'b000;
    alusrc_d    = 1'b0;
    immsrc_d    = 2'b00;
    resultsrc_d = 1'b0;

    unique case (state)
      S_FETCH: begin
        imem_req_d = 1'b1;
        // Ready in the last allowed cycle still wins over the timeout.
        if (imem_ready) begin
          irwrite_d  = 1'b1;
          state_next = S_DECODE;
        end else if (TO_EN && wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          state_next  = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_DECODE: begin
        if (dec_cls == C_NONE) begin
          set_illegal = 1'b1;
          state_next  = S_HALT;
        end else begin
          cls_next   = dec_cls;
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (cls)
          C_ADDI: begin
            alusrc_d   = 1'b1;
            state_next = S_WB;
          end
          C_LW: begin
            alusrc_d   = 1'b1;
            state_next = S_MEM;
          end
          C_BNE: begin
            aluctrl_d  = 3'b001;
            immsrc_d   = 2'b10;
            pcwrite_d  = 1'b1;
            pcsrc_d    = ~EQ;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_HALT;
        endcase
      end

      S_MEM: begin
        dmem_req_d = 1'b1;
        alusrc_d   = 1'b1;
        if (dmem_ready) begin
          state_next = S_WB;
        end else if (TO_EN && wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          state_next  = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_WB: begin
        regwrite_d  = 1'b1;
        resultsrc_d = (cls == C_LW);
        pcwrite_d   = 1'b1;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end

      S_HALT: state_next = S_HALT;

      default: state_next = S_HALT;
    endcase
  end

  // Strobes are masked while reset is high so nothing leaks out of the
  // FETCH decode during the reset pulse itself.
  assign imem_req  = imem_req_d  & ~rst;
  assign dmem_req  = dmem_req_d  & ~rst;
  assign IRWrite   = irwrite_d   & ~rst;
  assign PCWrite   = pcwrite_d   & ~rst;
  assign PCsrc     = pcsrc_d     & ~rst;
  assign RegWrite  = regwrite_d  & ~rst;
  assign ALUctrl   = rst ? 3'b000 : aluctrl_d;
  assign ALUsrc    = alusrc_d    & ~rst;
  assign ImmSrc    = rst ? 2'b00  : immsrc_d;
  assign Resultsrc = resultsrc_d & ~rst;
  assign state_o   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       op = '0;
  logic [2:0]       funct3 = '0;
  logic             EQ = 1'b0;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             imem_req, dmem_req, IRWrite, PCWrite, PCsrc, RegWrite;
  logic [2:0]       ALUctrl;
  logic             ALUsrc;
  logic [1:0]       ImmSrc;
  logic             Resultsrc, illegal, timeout;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_o;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .EQ(EQ),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCsrc(PCsrc), .RegWrite(RegWrite),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .Resultsrc(Resultsrc), .illegal(illegal), .timeout(timeout),
    .retired(retired), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       st;
    logic [12:0]      ctl;
    logic [1:0]       flg;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             sb[$];
  int               n_chk = 0;
  int               n_pass = 0;
  string            cur = "init";
  logic             exp_ill = 1'b0;
  logic             exp_to = 1'b0;
  logic [CNT_W-1:0] exp_ret = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", tag, obs, expv, $time);
  endtask

  // {imem_req, dmem_req, IRWrite, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc, Resultsrc}
  function automatic logic [12:0] mk(input logic im, input logic dm, input logic irw,
                                     input logic pcw, input logic pcs, input logic rw,
                                     input logic [2:0] alu, input logic asrc,
                                     input logic [1:0] imm, input logic rsrc);
    return {im, dm, irw, pcw, pcs, rw, alu, asrc, imm, rsrc};
  endfunction

  function automatic logic [12:0] obs_ctl();
    return {imem_req, dmem_req, IRWrite, PCWrite, PCsrc, RegWrite,
            ALUctrl, ALUsrc, ImmSrc, Resultsrc};
  endfunction

  localparam logic [12:0] NONE = 13'd0;

  // Inputs are already driven by the caller; push the expectation, pop and
  // compare it mid-cycle, then advance past the next rising edge.
  task automatic step(input logic [2:0] st, input logic [12:0] c);
    exp_t e;
    sb.push_back('{st: st, ctl: c, flg: {exp_ill, exp_to}, ret: exp_ret});
    @(negedge clk);
    e = sb.pop_front();
    chk({cur, ".state"},   32'(state_o),            32'(e.st));
    chk({cur, ".ctl"},     32'(obs_ctl()),          32'(e.ctl));
    chk({cur, ".flags"},   32'({illegal, timeout}), 32'(e.flg));
    chk({cur, ".retired"}, 32'(retired),            32'(e.ret));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst.ctl",     32'(obs_ctl()),          32'(NONE));
    chk("rst.state",   32'(state_o),            32'd0);
    chk("rst.retired", 32'(retired),            32'd0);
    chk("rst.flags",   32'({illegal, timeout}), 32'd0);
    exp_ret = '0; exp_ill = 1'b0; exp_to = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; EQ = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fetch(input int nwait);
    imem_ready = 1'b0;
    repeat (nwait) step(3'd0, mk(1,0,0,0,0,0,3'b000,0,2'b00,0));
    imem_ready = 1'b1;
    step(3'd0, mk(1,0,1,0,0,0,3'b000,0,2'b00,0));
    imem_ready = 1'b0;
  endtask

  task automatic decode(input logic [6:0] o, input logic [2:0] f);
    op = o; funct3 = f;
    step(3'd1, NONE);
  endtask

  task automatic do_addi(input int nwait);
    cur = "addi";
    fetch(nwait);
    decode(7'b0010011, 3'b000);
    step(3'd2, mk(0,0,0,0,0,0,3'b000,1,2'b00,0));
    step(3'd4, mk(0,0,0,1,0,1,3'b000,0,2'b00,0));
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic do_lw(input int nmw);
    cur = "lw";
    fetch(0);
    decode(7'b0000011, 3'b010);
    step(3'd2, mk(0,0,0,0,0,0,3'b000,1,2'b00,0));
    dmem_ready = 1'b0;
    repeat (nmw) step(3'd3, mk(0,1,0,0,0,0,3'b000,1,2'b00,0));
    dmem_ready = 1'b1;
    step(3'd3, mk(0,1,0,0,0,0,3'b000,1,2'b00,0));
    dmem_ready = 1'b0;
    step(3'd4, mk(0,0,0,1,0,1,3'b000,0,2'b00,1));
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic do_bne(input logic eq);
    cur = eq ? "bne_eq1" : "bne_eq0";
    fetch(0);
    decode(7'b1100011, 3'b001);
    EQ = eq;
    step(3'd2, mk(0,0,0,1,~eq,0,3'b001,0,2'b10,0));
    EQ = 1'b0;
    exp_ret = exp_ret + 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    do_addi(0);
    do_lw(3);
    do_bne(1'b0);
    do_bne(1'b1);

    // Stray dmem_ready during a fetch stall must be ignored.
    cur = "stray";
    dmem_ready = 1'b1;
    fetch(2);
    dmem_ready = 1'b0;
    decode(7'b0010011, 3'b000);
    step(3'd2, mk(0,0,0,0,0,0,3'b000,1,2'b00,0));
    step(3'd4, mk(0,0,0,1,0,1,3'b000,0,2'b00,0));
    exp_ret = exp_ret + 1'b1;

    // Enough branches to wrap the narrow counter.
    for (int i = 0; i < 5; i++) do_bne(1'($urandom_range(0, 1)));

    // Reset pulsed mid-MEM of a stalled lw.
    cur = "lw_rst";
    fetch(0);
    decode(7'b0000011, 3'b010);
    step(3'd2, mk(0,0,0,0,0,0,3'b000,1,2'b00,0));
    dmem_ready = 1'b0;
    step(3'd3, mk(0,1,0,0,0,0,3'b000,1,2'b00,0));
    chk("lw_rst.pre_dmem_req", 32'(dmem_req), 32'd1);
    do_reset();
    cur = "post_rst";
    step(3'd0, mk(1,0,0,0,0,0,3'b000,0,2'b00,0));
    do_addi(0);

    // Illegal opcode, then a long HALT with ready toggling.
    cur = "illegal";
    fetch(0);
    decode(7'b0110011, 3'b000);
    exp_ill = 1'b1;
    dmem_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      imem_ready = 1'(i % 2);
      step(3'd7, NONE);
    end
    do_reset();

    // Fetch timeout: TIMEOUT cycles of FETCH, then HALT.
    cur = "fetch_to";
    imem_ready = 1'b0;
    repeat (TIMEOUT) step(3'd0, mk(1,0,0,0,0,0,3'b000,0,2'b00,0));
    exp_to = 1'b1;
    imem_ready = 1'b1;
    step(3'd7, NONE);
    step(3'd7, NONE);
    do_reset();

    // Ready in the last allowed cycle wins.
    do_addi(TIMEOUT - 1);

    // Data-side timeout.
    cur = "mem_to";
    fetch(0);
    decode(7'b0000011, 3'b010);
    step(3'd2, mk(0,0,0,0,0,0,3'b000,1,2'b00,0));
    dmem_ready = 1'b0;
    repeat (TIMEOUT) step(3'd3, mk(0,1,0,0,0,0,3'b000,1,2'b00,0));
    exp_to = 1'b1;
    step(3'd7, NONE);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I-subset core (addi, bne, lw).
- Replaces the single-cycle combinational control unit.
- Steps the shared datapath (one ALU, one PC adder path, register file, IR) through FETCH/DECODE/EXEC/MEM/WB, with ready handshakes to the instruction and data memories.
- Flags illegal instructions and memory timeouts, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 16, max wait cycles in FETCH/MEM before halting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op  in  7  opcode field from IR; valid from DECODE onward.
- funct3  in  3  funct3 field from IR; valid from DECODE onward.
- EQ  in  1  ALU zero/equal flag, valid in EXEC.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory read data valid.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data load request.
- IRWrite  out  1  load IR from instruction memory.
- PCWrite  out  1  update PC.
- PCsrc  out  1  0 = PC+4, 1 = branch target.
- RegWrite  out  1  register file write enable.
- ALUctrl  out  3  000 = add, 001 = sub.
- ALUsrc  out  1  0 = register, 1 = immediate.
- ImmSrc  out  2  00 = I-type, 10 = B-type.
- Resultsrc  out  1  0 = ALU result, 1 = memory data.
- illegal  out  1  sticky illegal-instruction flag.
- timeout  out  1  sticky memory-timeout flag.
- retired  out  CNT_W  retired-instruction count.
- state_o  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = FETCH.
  - retired, illegal, timeout, wait counter and latched instruction class all cleared.
  - All strobes 0; no partial write may escape.
- Outputs:
  - All outputs are decoded from state plus the latched class (ADDI/LW/BNE).
  - IRWrite additionally depends on imem_ready; PCsrc additionally depends on EQ.
  - Any output not listed for a state is 0.
- FETCH:
  - imem_req = 1.
  - When imem_ready = 1: IRWrite = 1 that cycle, go to DECODE.
  - Otherwise the wait counter increments.
- DECODE:
  - Classify {op, funct3}: 0010011/000 = ADDI, 0000011/010 = LW, 1100011/001 = BNE.
  - Register the class and go to EXEC.
  - Any other combination: go to HALT and set illegal = 1.
- EXEC:
  - ADDI and LW: ALUctrl = 000, ALUsrc = 1, ImmSrc = 00. ADDI goes to WB; LW goes to MEM.
  - BNE: ALUctrl = 001, ALUsrc = 0, ImmSrc = 10, PCWrite = 1, PCsrc = ~EQ; retired increments; go to FETCH.
- MEM (LW only):
  - dmem_req = 1; ALU controls held at their EXEC values.
  - When dmem_ready = 1: go to WB. Otherwise the wait counter increments.
- WB:
  - RegWrite = 1, Resultsrc = 1 for LW and 0 for ADDI, PCWrite = 1, PCsrc = 0.
  - retired increments; go to FETCH.
- HALT:
  - All strobes 0; requests never reasserted.
  - Left only by reset; illegal and timeout hold their values.
- Timeout:
  - Wait counter is cleared on entry to FETCH and to MEM.
  - If TIMEOUT > 0, ready = 0 and counter = TIMEOUT-1: go to HALT and set timeout = 1.
  - Ready arriving in that same cycle wins: normal progress, no timeout.
- Latency with zero-wait memories: ADDI 4 cycles, LW 5, BNE 3. Each wait cycle adds 1.
- retired wraps modulo 2^CNT_W without flagging.
- Exactly one PCWrite pulse per retired instruction; RegWrite and PCWrite are never asserted outside WB/EXEC.
- imem_ready / dmem_ready arriving in states other than the one requesting them are ignored.

Test Plan:
- Reset, then addi (0010011/000) with imem_ready = 1 in the first FETCH cycle -> states 0,1,2,4 over 4 cycles. WB shows RegWrite = 1, PCWrite = 1, PCsrc = 0, Resultsrc = 0. EXEC shows ALUctrl = 000, ALUsrc = 1. retired = 1.
- lw (0000011/010) with dmem_ready low for 3 cycles -> dmem_req high for 4 consecutive cycles, WB Resultsrc = 1, total 8 cycles, retired +1.
- bne (1100011/001), EQ = 0 -> EXEC: ALUctrl = 001, ALUsrc = 0, ImmSrc = 10, PCWrite = 1, PCsrc = 1, RegWrite never high, 3 cycles. Repeat with EQ = 1 -> PCsrc = 0.
- op = 0110011 in DECODE -> state_o = 7 next cycle, illegal = 1; over 20 further cycles imem_req = 0 and retired unchanged.
- TIMEOUT = 8 with imem_ready held 0 -> 8 FETCH cycles, then HALT with timeout = 1. Separately, ready arriving in the 8th cycle -> DECODE, timeout = 0.
- rst pulsed during MEM of a lw -> same cycle: dmem_req = 0, RegWrite = 0, retired = 0. After release: state_o = 0, imem_req = 1.
